// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of a dual-clock FIFO: owns the read pointer, drives RAM read, derives empty/level flags.
// Optional sticky underflow detection is built when FIFO_RD_UNDERFLOW_EN is defined.
module fifo_rd_ctrl #(
    parameter int unsigned AWIDTH       = 3,
    parameter int unsigned ALMOST_EMPTY = 2
) (
    input  logic              rd_clk_i,
    input  logic              aclr_i,
    input  logic              rd_req_i,
    input  logic [AWIDTH:0]   wr_pntr_gray_i,
    output logic [AWIDTH-1:0] rd_addr_o,
    output logic              rd_en_o,
    output logic              rd_valid_o,
    output logic [AWIDTH:0]   rd_pntr_gray_o,
    output logic              rd_empty_o,
    output logic              rd_almost_empty_o,
    output logic [AWIDTH:0]   rd_usedw_o,
    output logic              rd_underflow_o
);

    localparam int unsigned PW = AWIDTH + 1;

    typedef enum logic {
        ST_EMPTY    = 1'b0,
        ST_NONEMPTY = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   rd_bin_q, rd_bin_d;
    logic [PW-1:0]   rd_gray_q, rd_gray_d;
    logic [PW-1:0]   usedw_q, usedw_d;
    logic [PW-1:0]   wr_bin_c;
    logic            aempty_q, aempty_d;
    logic            valid_q;
    logic            acc_c;

    // State register: EMPTY/NONEMPTY doubles as the registered empty flag
    always_ff @(posedge rd_clk_i or negedge aclr_i) begin
        if (!aclr_i) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state is decided by the post-edge read pointer against the synchronised write pointer
    always_comb begin
        state_d = state_q;
        if (rd_gray_d == wr_pntr_gray_i) begin
            state_d = ST_EMPTY;
        end else begin
            state_d = ST_NONEMPTY;
        end
    end

    // Output decode: accept only when not empty
    always_comb begin
        acc_c      = 1'b0;
        rd_empty_o = 1'b1;
        if (state_q == ST_NONEMPTY) begin
            acc_c      = rd_req_i;
            rd_empty_o = 1'b0;
        end
    end

    assign rd_en_o   = acc_c;
    assign rd_addr_o = rd_bin_q[AWIDTH-1:0];

    // Pointer advance, Gray encode, and fill level from the synchronised write pointer
    always_comb begin
        wr_bin_c = '0;
        for (int unsigned i = 0; i < PW; i++) begin
            wr_bin_c[i] = ^(wr_pntr_gray_i >> i);
        end
        rd_bin_d  = rd_bin_q + PW'(acc_c);
        rd_gray_d = rd_bin_d ^ (rd_bin_d >> 1);
        usedw_d   = wr_bin_c - rd_bin_d;
        aempty_d  = (32'(usedw_d) <= ALMOST_EMPTY);
    end

    always_ff @(posedge rd_clk_i or negedge aclr_i) begin
        if (!aclr_i) begin
            rd_bin_q  <= '0;
            rd_gray_q <= '0;
            usedw_q   <= '0;
            aempty_q  <= 1'b1;
            valid_q   <= 1'b0;
        end else begin
            rd_bin_q  <= rd_bin_d;
            rd_gray_q <= rd_gray_d;
            usedw_q   <= usedw_d;
            aempty_q  <= aempty_d;
            valid_q   <= acc_c;
        end
    end

    assign rd_pntr_gray_o    = rd_gray_q;
    assign rd_usedw_o        = usedw_q;
    assign rd_almost_empty_o = aempty_q;
    assign rd_valid_o        = valid_q;

`ifdef FIFO_RD_UNDERFLOW_EN
    logic underflow_q;

    // Sticky until reset: a request seen while empty
    always_ff @(posedge rd_clk_i or negedge aclr_i) begin
        if (!aclr_i) begin
            underflow_q <= 1'b0;
        end else if (rd_req_i && (state_q == ST_EMPTY)) begin
            underflow_q <= 1'b1;
        end
    end

    assign rd_underflow_o = underflow_q;
`else
    assign rd_underflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl with an arithmetic reference model checked every cycle.
module tb_fifo_rd_ctrl;

    localparam int unsigned AW    = 3;
    localparam int          AE    = 2;
    localparam int          PMOD  = 16;
`ifdef FIFO_RD_UNDERFLOW_EN
    localparam bit UF_EN = 1'b1;
`else
    localparam bit UF_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          aclr;
    logic          rd_req;
    logic [AW:0]   wr_gray;
    logic [AW-1:0] rd_addr;
    logic          rd_en, rd_valid, rd_empty, rd_aempty, rd_uf;
    logic [AW:0]   rd_gray, rd_usedw;

    int checks = 0;
    int errors = 0;

    fifo_rd_ctrl #(.AWIDTH(AW), .ALMOST_EMPTY(AE)) dut (
        .rd_clk_i          (clk),
        .aclr_i            (aclr),
        .rd_req_i          (rd_req),
        .wr_pntr_gray_i    (wr_gray),
        .rd_addr_o         (rd_addr),
        .rd_en_o           (rd_en),
        .rd_valid_o        (rd_valid),
        .rd_pntr_gray_o    (rd_gray),
        .rd_empty_o        (rd_empty),
        .rd_almost_empty_o (rd_aempty),
        .rd_usedw_o        (rd_usedw),
        .rd_underflow_o    (rd_uf)
    );

    always #5 clk = ~clk;

    function automatic int to_gray(input int b);
        return b ^ (b >> 1);
    endfunction

    // Decode by search: the binary value whose Gray code matches
    function automatic int from_gray(input int g);
        for (int b = 0; b < PMOD; b++) begin
            if (to_gray(b) == g) return b;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: fill level as plain modular distance between pointers
    int m_ptr;
    int m_usedw;
    bit m_empty, m_aempty, m_valid, m_uf;

    always @(posedge clk or negedge aclr) begin
        bit acc;
        if (!aclr) begin
            m_ptr = 0; m_usedw = 0; m_empty = 1; m_aempty = 1; m_valid = 0; m_uf = 0;
        end else begin
            acc = rd_req && !m_empty;
            if (UF_EN && rd_req && m_empty) m_uf = 1;
            m_valid  = acc;
            m_ptr    = (m_ptr + int'(acc)) % PMOD;
            m_usedw  = (from_gray(int'(wr_gray)) - m_ptr + PMOD) % PMOD;
            m_empty  = (m_usedw == 0);
            m_aempty = (m_usedw <= AE);
        end
    end

    always @(negedge clk) begin
        chk("m_empty",  int'(rd_empty),  int'(m_empty));
        chk("m_aempty", int'(rd_aempty), int'(m_aempty));
        chk("m_usedw",  int'(rd_usedw),  m_usedw);
        chk("m_gray",   int'(rd_gray),   to_gray(m_ptr));
        chk("m_valid",  int'(rd_valid),  int'(m_valid));
        chk("m_uf",     int'(rd_uf),     int'(m_uf));
        chk("m_en",     int'(rd_en),     int'(rd_req && !m_empty));
        chk("m_addr",   int'(rd_addr),   m_ptr % 8);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        aclr = 1'b0; rd_req = 1'b0; wr_gray = '0;
        step(); step();
        aclr = 1'b1;
        chk("rst_empty", int'(rd_empty), 1);
        chk("rst_aempty", int'(rd_aempty), 1);
        chk("rst_usedw", int'(rd_usedw), 0);
        chk("rst_gray", int'(rd_gray), 0);

        // Three words available, drained back to back
        wr_gray = 4'b0010;
        step();
        chk("t2_empty", int'(rd_empty), 0);
        chk("t2_usedw", int'(rd_usedw), 3);
        chk("t2_aempty", int'(rd_aempty), 0);
        for (int i = 0; i < 3; i++) begin
            rd_req = 1'b1;
            #1;
            chk("t2_en", int'(rd_en), 1);
            chk("t2_addr", int'(rd_addr), i);
            step();
            chk("t2_valid", int'(rd_valid), 1);
        end
        rd_req = 1'b0;
        chk("t2_empty_end", int'(rd_empty), 1);
        chk("t2_usedw_end", int'(rd_usedw), 0);
        chk("t2_gray_end", int'(rd_gray), 4'b0010);
        step();
        chk("t2_valid_off", int'(rd_valid), 0);

        // Requests while empty are ignored
        rd_req = 1'b1;
        repeat (4) begin
            #1;
            chk("t3_en", int'(rd_en), 0);
            chk("t3_addr", int'(rd_addr), 3);
            step();
            chk("t3_valid", int'(rd_valid), 0);
        end
        rd_req = 1'b0;
        chk("t3_uf", int'(rd_uf), int'(UF_EN));
        chk("t3_gray", int'(rd_gray), 4'b0010);

        // Streamed write/read pairs across the pointer wrap
        wr_gray = 4'b0110;
        step();
        chk("t4_empty0", int'(rd_empty), 0);
        chk("t4_usedw0", int'(rd_usedw), 1);
        for (int k = 0; k < 16; k++) begin
            wr_gray = 4'(to_gray((5 + k) % PMOD));
            rd_req  = 1'b1;
            step();
            chk("t4_empty", int'(rd_empty), 0);
            if (k == 11) begin
                chk("t4_gray15", int'(rd_gray), 4'b1000);
                chk("t4_addr7", int'(rd_addr), 7);
            end
            if (k == 12) begin
                chk("t4_gray0", int'(rd_gray), 4'b0000);
                chk("t4_addr0", int'(rd_addr), 0);
            end
        end

        // Reset while reads are in flight
        aclr = 1'b0;
        #1;
        chk("t1_empty", int'(rd_empty), 1);
        chk("t1_usedw", int'(rd_usedw), 0);
        chk("t1_gray", int'(rd_gray), 0);
        chk("t1_valid", int'(rd_valid), 0);
        chk("t1_uf", int'(rd_uf), 0);
        rd_req = 1'b0; wr_gray = '0;
        step();
        aclr = 1'b1;

        // Full level, then down to almost-empty
        wr_gray = 4'b1100;
        step();
        chk("t5_usedw8", int'(rd_usedw), 8);
        chk("t5_aempty0", int'(rd_aempty), 0);
        chk("t5_empty0", int'(rd_empty), 0);
        rd_req = 1'b1;
        repeat (6) step();
        rd_req = 1'b0;
        chk("t5_usedw2", int'(rd_usedw), 2);
        chk("t5_aempty1", int'(rd_aempty), 1);

        // Last word read on the same edge the write pointer advances
        aclr = 1'b0;
        #1;
        aclr = 1'b1;
        wr_gray = 4'b0001;
        step();
        chk("t6_usedw_pre", int'(rd_usedw), 1);
        wr_gray = 4'b0011;
        rd_req  = 1'b1;
        step();
        rd_req = 1'b0;
        chk("t6_empty", int'(rd_empty), 0);
        chk("t6_usedw", int'(rd_usedw), 1);
        chk("t6_valid", int'(rd_valid), 1);
        chk("t6_gray", int'(rd_gray), 4'b0001);
        step();
        chk("t6_valid_off", int'(rd_valid), 0);
        step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
